// File: rtl/dat_mem_pkg.sv
// ---------------------------------------------------------------------------
// dat_mem_pkg
// Shared definitions for the data-memory reader and its companion memory.
//   ADDR_W / DATA_W : memory address and data widths
//   MAX_LEN         : largest transfer in bytes (one full sweep of the memory)
//   LEN_W           : width of the byte-count input (holds 0..MAX_LEN)
//   state_e         : reader FSM states
//   clamp_len()     : saturates a requested length at MAX_LEN
// ---------------------------------------------------------------------------
package dat_mem_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Requests longer than the memory are trimmed to one full sweep.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return len;
  endfunction

endpackage

// File: rtl/dat_mem.sv
// ---------------------------------------------------------------------------
// dat_mem
// Simple 256 x 8 data memory paired with dat_mem_reader.
//   clk   : write clock
//   we    : write enable (preload port, used by whoever owns the memory)
//   waddr : write address
//   wdata : write data
//   raddr : read address (from the reader's mem_addr)
//   rdata : combinational read data for raddr, valid in the same cycle
// ---------------------------------------------------------------------------
module dat_mem
  import dat_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dat_mem_reader.sv
// ---------------------------------------------------------------------------
// dat_mem_reader
// Reads a run of bytes from a combinational-read data memory and streams them
// out over a valid/ready interface, accumulating a mod-256 checksum.
//
// Ports
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   go           : single-cycle transfer request, only honoured in IDLE
//   base_addr    : first byte address, captured with an accepted go
//   len          : byte count 0..256 (larger values act as 256)
//   mem_addr     : memory read address, a register (the read pointer)
//   mem_data     : memory read data for mem_addr, same cycle
//   out_data     : streamed byte
//   out_valid    : out_data holds a byte
//   out_ready    : sink can take the byte
//   busy         : high while fetching / sending
//   done         : one-cycle pulse when a transfer finishes
//   checksum     : mod-256 sum of bytes handshaken in the current/last transfer
//   state_dbg    : current FSM state, for observation only
//
// Handshake: a byte moves when out_valid & out_ready are both high at a rising
// edge. Once out_valid rises it stays high with out_data unchanged until that
// byte is taken; the source never retracts or alters an offered byte.
// ---------------------------------------------------------------------------
module dat_mem_reader
  import dat_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output state_e            state_dbg
);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [DATA_W-1:0] checksum_q,  checksum_d;

  logic handshake;

  assign handshake = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    checksum_d  = checksum_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          checksum_d = '0;
          if (len != '0) begin
            ptr_d       = base_addr;
            remaining_d = clamp_len(len);
            busy_d      = 1'b1;
            state_d     = ST_FETCH;
          end else begin
            // Empty transfer: straight to the done pulse, nothing emitted.
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_FETCH: begin
        // mem_addr already shows ptr; capture the first byte.
        out_data_d  = mem_data;
        out_valid_d = 1'b1;
        ptr_d       = ptr_q + 1'b1;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (handshake) begin
          checksum_d  = checksum_q + out_data_q;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q > LEN_W'(1)) begin
            // ptr already points at the next byte, so mem_data is ready to
            // replace the one just taken: one byte per cycle, no bubble.
            out_data_d = mem_data;
            ptr_d      = ptr_q + 1'b1;
          end else begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // Any go here is dropped; only IDLE accepts requests.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign mem_addr  = ptr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_dat_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_dat_mem_reader
// Self-checking bench for dat_mem_reader paired with a dat_mem instance.
// Expected byte streams and checksums come from a plain array image of the
// memory: byte k of a transfer is image[(base + k) mod 256], the checksum is
// the mod-256 sum of those bytes.
// ---------------------------------------------------------------------------
module tb_dat_mem_reader;
  import dat_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT + memory ----------------
  logic              go = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;
  state_e            state_dbg;

  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_waddr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;

  dat_mem_reader dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .base_addr (base_addr),
    .len       (len),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .state_dbg (state_dbg)
  );

  dat_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_addr),
    .rdata (mem_data)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] image [256];
  logic [DATA_W-1:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // mode 0: identity image, 1: random image
  task automatic preload(input int mode);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      mem_we    = 1'b1;
      mem_waddr = 8'(i);
      mem_wdata = (mode == 0) ? 8'(i) : 8'($urandom_range(0, 255));
      image[i]  = mem_wdata;
    end
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  // ready_mode 0: always ready, 1: pattern 1,0,0 repeating, 2: random with
  // stray go pulses during the transfer. go_in_done pulses go in DONE.
  task automatic do_xfer(input logic [7:0] b, input logic [8:0] l,
                         input int ready_mode, input bit go_in_done,
                         output logic [7:0] sum_out);
    int n;
    int cyc;
    int hs_idx;
    bit first_seen;
    bit prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp_sum;
    logic [7:0] e;

    n = (l > 9'd256) ? 256 : int'(l);
    exp_q.delete();
    exp_sum = 8'h00;
    for (int k = 0; k < n; k++) begin
      e = image[(int'(b) + k) % 256];
      exp_q.push_back(e);
      exp_sum = exp_sum + e;
    end
    sum_out = exp_sum;

    @(negedge clk);
    go = 1'b1; base_addr = b; len = l; out_ready = 1'b0;
    cyc = 0; hs_idx = 0; first_seen = 0; prev_stall = 0; prev_data = '0;

    forever begin
      @(negedge clk);
      cyc++;
      go = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && !first_seen) begin
        first_seen = 1;
        chk("first_latency", cyc, 2);
      end
      if (done) begin
        chk("left_bytes", exp_q.size(), 0);
        chk("done_checksum", 32'(checksum), 32'(exp_sum));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_valid", 32'(out_valid), 32'd0);
        if (n == 0) chk("empty_done_cycle", cyc, 1);
        if (ready_mode == 0 && n != 0) chk("done_cycle", cyc, n + 2);
        break;
      end
      chk("busy_mid", 32'(busy), (n == 0) ? 32'd0 : 32'd1);
      if (cyc > 2000) begin
        chk("timeout", cyc, 0);
        break;
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc < 2) ? 1'b1 : ((cyc - 2) % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("byte", 32'(out_data), 32'(exp_q.pop_front()));
          if (ready_mode == 0) chk("byte_cycle", cyc, hs_idx + 2);
        end
        hs_idx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      // stray requests while busy must be ignored
      if (ready_mode == 2) go = ($urandom_range(0, 3) == 0);
      base_addr = 8'($urandom_range(0, 255));
    end

    go = go_in_done;
    @(negedge clk);
    go = 1'b0;
    chk("done_one_pulse", 32'(done), 32'd0);
    chk("idle_after_done", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    chk("no_queued_go", 32'(busy), 32'd0);
    chk("hold_checksum", 32'(checksum), 32'(exp_sum));
    out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] s;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;

    preload(0);

    do_xfer(8'h10, 9'd4, 0, 0, s);
    chk("sum_10_4", 32'(checksum), 32'h46);
    do_xfer(8'hFE, 9'd4, 0, 0, s);
    chk("sum_wrap", 32'(checksum), 32'hFE);
    do_xfer(8'($urandom_range(0, 255)), 9'd3, 1, 0, s);
    do_xfer(8'h33, 9'd0, 0, 0, s);
    chk("sum_empty", 32'(checksum), 32'h00);
    do_xfer(8'h80, 9'd256, 0, 1, s);
    chk("sum_full", 32'(checksum), 32'h80);
    repeat (3) @(negedge clk);
    chk("sum_hold_idle", 32'(checksum), 32'h80);
    do_xfer(8'($urandom_range(0, 255)), 9'($urandom_range(257, 511)), 0, 0, s);

    preload(1);
    for (int t = 0; t < 6; t++) begin
      do_xfer(8'($urandom_range(0, 255)), 9'($urandom_range(0, 40)), 2, bit'($urandom_range(0, 1)), s);
    end

    // abandon a len=8 transfer after its 2nd byte; reset also beats a go
    preload(0);
    @(negedge clk);
    go = 1'b1; base_addr = 8'h20; len = 9'd8; out_ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("pre_rst_byte0", 32'(out_data), 32'h20);
    @(negedge clk);
    chk("pre_rst_byte1", 32'(out_data), 32'h21);
    @(negedge clk);
    reset = 1'b1; go = 1'b1;
    @(negedge clk);
    reset = 1'b0; go = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_checksum", 32'(checksum), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    do_xfer(8'h5A, 9'd1, 0, 0, s);
    chk("sum_after_rst", 32'(checksum), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dat_mem_reader.md
DAT_MEM_READER -- requirements
Module: dat_mem_reader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: go  input  1  single-cycle transfer request; sampled only in IDLE.
REQ-005 Port: base_addr  input  8  first byte address, sampled with an accepted go.
REQ-006 Port: len  input  9  byte count 0..256, sampled with an accepted go; values above 256 are treated as 256.
REQ-007 Port: mem_addr  output  8  read address to the data memory, driven straight from a register.
REQ-008 Port: mem_data  input  8  combinational read data for mem_addr, valid in the same cycle.
REQ-009 Port: out_data  output  8  streamed byte.
REQ-010 Port: out_valid  output  1  out_data holds a byte.
REQ-011 Port: out_ready  input  1  sink accepts the byte; a handshake is out_valid & out_ready.
REQ-012 Port: busy  output  1  high in FETCH and SEND.
REQ-013 Port: done  output  1  one-cycle pulse when a transfer completes.
REQ-014 Port: checksum  output  8  mod-256 sum of all bytes handshaken in the current or last transfer.

Function
REQ-015 SHALL implement the states IDLE, FETCH, SEND and DONE.
REQ-016 IDLE, on go with len!=0:
- ptr<=base_addr, remaining<=len (clamped), checksum<=0
- next state FETCH.
REQ-017 IDLE, on go with len==0:
- checksum<=0
- next state DONE (no bytes emitted).
REQ-018 FETCH: mem_addr=ptr; out_data<=mem_data, out_valid<=1, ptr<=ptr+1; next state SEND.
REQ-019 SEND on a handshake with remaining>1:
- checksum<=checksum+out_data, remaining<=remaining-1
- out_data<=mem_data, ptr<=ptr+1
- stay in SEND with out_valid held at 1; this sustains one byte per cycle.
REQ-020 SEND on a handshake with remaining==1:
- checksum updated as in REQ-019
- out_valid<=0; next state DONE.
REQ-021 SEND without a handshake: out_data, ptr, remaining and checksum SHALL hold; out_valid SHALL stay 1 (no retraction).
REQ-022 DONE: done=1 for exactly one cycle; next state IDLE; busy=0.
REQ-023 Latency: the first out_valid SHALL occur 2 cycles after the cycle in which go is accepted.
REQ-024 ptr and mem_addr SHALL wrap from 255 to 0 with no error or stall; len=256 reads every address exactly once.
REQ-025 go SHALL be ignored in FETCH, SEND and DONE; a go in DONE is not queued.
REQ-026 checksum arithmetic is 8-bit with carry discarded; the value SHALL hold from DONE until the next accepted go.
REQ-027 The block SHALL never write memory; it has no write-enable or write-data outputs.

Reset
REQ-028 When reset is high at a clock edge:
- state IDLE
- ptr=0, remaining=0, mem_addr=0, out_data=0, checksum=0
- out_valid=0, busy=0, done=0.
REQ-029 Reset mid-transfer SHALL abandon the transfer without a done pulse; the next transfer starts clean.
REQ-030 Reset SHALL dominate a go in the same cycle.

Structure
REQ-031 A shared package dat_mem_pkg SHALL hold:
- the state enum
- ADDR_W=8, DATA_W=8, MAX_LEN=256.
REQ-032 No sub-module is required; the FSM, address counter and checksum live in one module; benches pair it with a dat_mem instance.

Verification
REQ-033 Memory preloaded with mem[i]=i; go, base_addr=0x10, len=4, out_ready=1 -> bytes 0x10,0x11,0x12,0x13 on consecutive cycles; first byte 2 cycles after go; done pulses once; checksum=0x46.
REQ-034 Same preload; base_addr=0xFE, len=4 -> bytes 0xFE,0xFF,0x00,0x01; checksum=0xFE.
REQ-035 len=3, out_ready toggling 1,0,0,1,... -> out_data stable while stalled; exactly 3 handshakes; done pulses once after the last handshake.
REQ-036 go with len=0 -> no out_valid; done pulses 1 cycle later; checksum=0.
REQ-037 len=256, base_addr=0x80, out_ready=1 -> 256 bytes, all addresses visited once; checksum=0x80 (sum of 0..255 mod 256).
REQ-038 reset asserted after the 2nd byte of a len=8 transfer -> next cycle out_valid=0, busy=0, checksum=0, no done; a following len=1 transfer completes normally.
